// File: rtl/bj_resolve_unit_pkg.sv
// bj_resolve_unit_pkg: BJ op codes and resolver FSM state encodings
package bj_resolve_unit_pkg;
    localparam logic [7:0] OP_INVALID = 8'h00;
    localparam logic [7:0] OP_JIRL    = 8'h01;
    localparam logic [7:0] OP_B       = 8'h02;
    localparam logic [7:0] OP_BL      = 8'h03;
    localparam logic [7:0] OP_BEQ     = 8'h04;
    localparam logic [7:0] OP_BNE     = 8'h05;
    localparam logic [7:0] OP_BLT     = 8'h06;
    localparam logic [7:0] OP_BGE     = 8'h07;
    localparam logic [7:0] OP_BLTU    = 8'h08;
    localparam logic [7:0] OP_BGEU    = 8'h09;
    typedef enum logic {
        BJ_ST_RUN  = 1'b0,
        BJ_ST_KILL = 1'b1
    } bj_state_e;
endpackage

// File: rtl/bj_resolve_unit_cond_eval.sv
// bj_cond_eval: combinational taken/target/link/adef evaluation for one BJ op
module bj_cond_eval
    import bj_resolve_unit_pkg::*;
(
    input  logic [7:0]  op_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rj_i,
    input  logic [31:0] rkd_i,
    input  logic [31:0] imm_i,
    output logic        taken_o,
    output logic        link_we_o,
    output logic [31:0] target_o,
    output logic        adef_o
);
    // condition evaluation; unknown codes behave like OP_INVALID
    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            OP_JIRL, OP_B, OP_BL: taken_o = 1'b1;
            OP_BEQ:  taken_o = rj_i == rkd_i;
            OP_BNE:  taken_o = rj_i != rkd_i;
            OP_BLT:  taken_o = $signed(rj_i) < $signed(rkd_i);
            OP_BGE:  taken_o = $signed(rj_i) >= $signed(rkd_i);
            OP_BLTU: taken_o = rj_i < rkd_i;
            OP_BGEU: taken_o = rj_i >= rkd_i;
            default: taken_o = 1'b0;
        endcase
    end
    assign target_o  = (op_i == OP_JIRL ? rj_i : pc_i) + imm_i;
    assign link_we_o = (op_i == OP_BL) | (op_i == OP_JIRL);
    assign adef_o    = taken_o & |target_o[1:0];
endmodule

// File: rtl/bj_resolve_unit.sv
// bj_resolve_unit: registered branch/jump resolver with redirect and wrong-path kill; BJ_PERF_EN adds op counters
module bj_resolve_unit
    import bj_resolve_unit_pkg::*;
#(
    parameter int SHADOW_DEPTH = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_op,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rj,
    input  logic [31:0] in_rkd,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_link,
    output logic        out_link_we,
    output logic        out_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        out_adef
`ifdef BJ_PERF_EN
    ,
    output logic [31:0] perf_bj_cnt,
    output logic [31:0] perf_taken_cnt
`endif
);
    bj_state_e   state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        out_valid_q, out_valid_d;
    logic        redirect_valid_q;
    logic        taken, link_we, adef, kill, acc, load, drop;
    logic [31:0] target;

    bj_cond_eval u_cond (
        .op_i      (in_op),
        .pc_i      (in_pc),
        .rj_i      (in_rj),
        .rkd_i     (in_rkd),
        .imm_i     (in_imm),
        .taken_o   (taken),
        .link_we_o (link_we),
        .target_o  (target),
        .adef_o    (adef)
    );

    assign kill        = state_q == BJ_ST_KILL;
    assign in_ready    = kill | ~out_valid_q | out_ready;
    assign acc         = in_valid & in_ready & ~flush_in;
    assign load        = acc & ~kill;
    assign drop        = acc & kill;
    assign out_valid_d = ~flush_in & (load | (out_valid_q & ~out_ready));
    assign out_valid      = out_valid_q;
    assign redirect_valid = redirect_valid_q;

    // next state: flush wins, a taken op arms the kill window, each drop counts down
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_in) begin
            state_d = BJ_ST_RUN;
            cnt_d   = 3'd0;
        end else if (load & taken) begin
            state_d = BJ_ST_KILL;
            cnt_d   = 3'(SHADOW_DEPTH);
        end else if (drop) begin
            cnt_d   = cnt_q - 3'd1;
            state_d = cnt_q == 3'd1 ? BJ_ST_RUN : BJ_ST_KILL;
        end
    end

    // state register and kill counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BJ_ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // result register and one-cycle redirect strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q      <= 1'b0;
            out_pc           <= 32'd0;
            out_link         <= 32'd0;
            out_link_we      <= 1'b0;
            out_taken        <= 1'b0;
            out_adef         <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc      <= 32'd0;
        end else begin
            out_valid_q      <= out_valid_d;
            redirect_valid_q <= load & taken;
            if (load) begin
                out_pc      <= in_pc;
                out_link    <= in_pc + 32'd4;
                out_link_we <= link_we;
                out_taken   <= taken;
                out_adef    <= adef;
            end
            if (load & taken)
                redirect_pc <= target;
        end
    end

`ifdef BJ_PERF_EN
    // resolved-op and taken-op counters, free-running wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_bj_cnt    <= 32'd0;
            perf_taken_cnt <= 32'd0;
        end else begin
            perf_bj_cnt    <= perf_bj_cnt + {31'd0, load};
            perf_taken_cnt <= perf_taken_cnt + {31'd0, load & taken};
        end
    end
`endif
endmodule

// File: tb/tb_bj_resolve_unit.sv
// tb_bj_resolve_unit: directed and randomized check of bj_resolve_unit against a behavioural model
module tb_bj_resolve_unit;
    import bj_resolve_unit_pkg::*;
    localparam int SD = 2;

    logic        clk = 1'b0, reset, flush_in, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_op;
    logic [31:0] in_pc, in_rj, in_rkd, in_imm, out_pc, out_link, redirect_pc;
    logic        out_link_we, out_taken, redirect_valid, out_adef;
`ifdef BJ_PERF_EN
    logic [31:0] perf_bj_cnt, perf_taken_cnt;
`endif

    int n_cmp = 0, n_err = 0;

    bit          m_ov, m_lwe, m_tk, m_adef, m_rv;
    logic [31:0] m_pc, m_link, m_rpc, m_bj, m_tkc;
    int          m_kill;
    logic [7:0]  ops [10];

    always #5 clk = ~clk;

    bj_resolve_unit #(.SHADOW_DEPTH(SD)) dut (
        .clk(clk), .reset(reset), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_pc(in_pc),
        .in_rj(in_rj), .in_rkd(in_rkd), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_link(out_link),
        .out_link_we(out_link_we), .out_taken(out_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_adef(out_adef)
`ifdef BJ_PERF_EN
        , .perf_bj_cnt(perf_bj_cnt), .perf_taken_cnt(perf_taken_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic bit m_taken(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_JIRL, OP_B, OP_BL: return 1'b1;
            OP_BEQ:  return a == b;
            OP_BNE:  return a != b;
            OP_BLT:  return $signed(a) < $signed(b);
            OP_BGE:  return $signed(a) >= $signed(b);
            OP_BLTU: return a < b;
            OP_BGEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic compare_model();
        chk("out_valid", out_valid, m_ov);
        chk("redirect_valid", redirect_valid, m_rv);
        if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
        if (m_ov) begin
            chk("out_pc", out_pc, m_pc);
            chk("out_link", out_link, m_link);
            chk("out_link_we", out_link_we, m_lwe);
            chk("out_taken", out_taken, m_tk);
            chk("out_adef", out_adef, m_adef);
        end
`ifdef BJ_PERF_EN
        chk("perf_bj_cnt", perf_bj_cnt, m_bj);
        chk("perf_taken_cnt", perf_taken_cnt, m_tkc);
`endif
    endtask

    task automatic step(input bit v, input logic [7:0] op, input logic [31:0] pc, input logic [31:0] rj,
                        input logic [31:0] rkd, input logic [31:0] imm, input bit ordy, input bit fl);
        bit rdy, tk;
        logic [31:0] tg;
        in_valid = v; in_op = op; in_pc = pc; in_rj = rj; in_rkd = rkd; in_imm = imm;
        out_ready = ordy; flush_in = fl;
        #1;
        rdy = m_kill > 0 || !m_ov || ordy;
        chk("in_ready", in_ready, rdy);
        if (fl) begin
            m_ov = 0; m_kill = 0; m_rv = 0;
        end else begin
            m_rv = 0;
            if (ordy) m_ov = 0;
            if (v && rdy) begin
                if (m_kill > 0) m_kill--;
                else begin
                    tk = m_taken(op, rj, rkd);
                    tg = (op == OP_JIRL ? rj : pc) + imm;
                    m_ov = 1; m_pc = pc; m_link = pc + 4;
                    m_lwe = op == OP_BL || op == OP_JIRL;
                    m_tk = tk; m_adef = tk && (tg % 4 != 0);
                    m_bj++;
                    if (tk) begin
                        m_tkc++; m_rv = 1; m_rpc = tg; m_kill = SD;
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        ops = '{OP_INVALID, OP_JIRL, OP_B, OP_BL, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
        m_ov = 0; m_lwe = 0; m_tk = 0; m_adef = 0; m_rv = 0;
        m_pc = 0; m_link = 0; m_rpc = 0; m_bj = 0; m_tkc = 0; m_kill = 0;
        reset = 1; flush_in = 0; in_valid = 0; in_op = 0; in_pc = 0; in_rj = 0; in_rkd = 0; in_imm = 0;
        out_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_out_taken", out_taken, 0);
        chk("rst_out_link_we", out_link_we, 0);
        chk("rst_out_adef", out_adef, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_link", out_link, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        reset = 0;
        @(negedge clk);

        step(1, OP_BEQ, 32'h1C000000, 5, 5, 32'h40, 1, 0);
        chk("beq_taken", out_taken, 1);
        chk("beq_redirect_valid", redirect_valid, 1);
        chk("beq_redirect_pc", redirect_pc, 32'h1C000040);
        step(1, OP_B, 32'h1C000004, 0, 0, 32'h8, 1, 0);
        chk("beq_shadow1_valid", out_valid, 0);
        chk("beq_shadow1_redirect", redirect_valid, 0);
        step(1, OP_B, 32'h1C000008, 0, 0, 32'h8, 1, 0);
        chk("beq_shadow2_valid", out_valid, 0);
        step(1, OP_BEQ, 32'h100, 1, 2, 32'h8, 1, 0);
        chk("third_valid", out_valid, 1);
        chk("third_pc", out_pc, 32'h100);
        chk("third_taken", out_taken, 0);

        step(1, OP_BLT, 32'h200, 32'hFFFFFFFF, 1, 32'h20, 1, 0);
        chk("blt_taken", out_taken, 1);
        chk("blt_redirect_pc", redirect_pc, 32'h220);
        step(1, OP_INVALID, 0, 0, 0, 0, 1, 0);
        step(1, OP_INVALID, 0, 0, 0, 0, 1, 0);
        step(1, OP_BLTU, 32'h300, 32'hFFFFFFFF, 1, 32'h20, 1, 0);
        chk("bltu_taken", out_taken, 0);
        chk("bltu_redirect", redirect_valid, 0);

        step(1, OP_JIRL, 32'h1C000800, 32'h1C001002, 0, 0, 1, 0);
        chk("jirl_link", out_link, 32'h1C000804);
        chk("jirl_link_we", out_link_we, 1);
        chk("jirl_adef", out_adef, 1);
        chk("jirl_redirect_pc", redirect_pc, 32'h1C001002);
        step(1, OP_INVALID, 0, 0, 0, 0, 1, 0);
        step(1, OP_INVALID, 0, 0, 0, 0, 1, 0);

        step(1, OP_BL, 32'h1C002000, 0, 0, 32'h100, 1, 0);
        chk("bl_redirect", redirect_valid, 1);
        step(1, OP_B, 32'h1C002004, 0, 0, 32'h4, 0, 0);
        chk("bl_stall1_redirect", redirect_valid, 0);
        chk("bl_stall1_link", out_link, 32'h1C002004);
        step(1, OP_B, 32'h1C002008, 0, 0, 32'h4, 0, 0);
        step(1, OP_BEQ, 32'h1C00200C, 0, 0, 32'h4, 0, 0);
        chk("bl_stall_in_ready", in_ready, 0);
        chk("bl_stall_valid", out_valid, 1);
        chk("bl_stall_pc", out_pc, 32'h1C002000);
        chk("bl_stall_link_we", out_link_we, 1);
        step(0, OP_INVALID, 0, 0, 0, 0, 1, 0);

        step(1, OP_B, 32'h400, 0, 0, 32'h10, 1, 0);
        step(1, OP_BEQ, 32'h404, 0, 0, 32'h10, 1, 1);
        chk("flush_valid", out_valid, 0);
        chk("flush_redirect", redirect_valid, 0);
        step(1, OP_BNE, 32'h500, 1, 1, 32'h10, 1, 0);
        chk("post_flush_valid", out_valid, 1);
        chk("post_flush_pc", out_pc, 32'h500);
        chk("post_flush_taken", out_taken, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [7:0]  op;
            logic [31:0] rj, rkd;
            int r;
            r = $urandom_range(0, 10);
            op = r < 10 ? ops[r] : 8'($urandom);
            rj = $urandom;
            rkd = $urandom_range(0, 2) == 0 ? rj : $urandom;
            step($urandom_range(0, 3) != 0, op, $urandom & 32'hFFFFFFFC, rj, rkd,
                 $urandom & 32'hFFFFFFFC, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
